// File: rtl/fib_pkg.sv
// Shared types and constants for the sequential Fibonacci engine.
package fib_pkg;

  localparam int unsigned DefW  = 32;
  localparam int unsigned DefNw = 8;

  // Seed values of the iteration: a = F(0), b = F(1).
  localparam int unsigned FIB_A0 = 0;
  localparam int unsigned FIB_B0 = 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } fib_state_e;

endpackage

// File: rtl/fib_seq_arb_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// The priority bit lives in the caller; prio names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       owner
);

  // Pick a single requester directly, fall back to priority on a tie.
  always_comb begin
    owner = prio;
    if (req == 2'b01) begin
      owner = 1'b0;
    end else if (req == 2'b10) begin
      owner = 1'b1;
    end
    grant = 2'b00;
    if (enable && (|req)) begin
      grant[owner] = 1'b1;
    end
  end

endmodule

// File: rtl/fib_seq_arb.sv
// Iterative Fibonacci engine shared by two requesters, one step per clock.
// Optional build macro FIB_OVERFLOW_EN adds a sticky carry-out flag on port ovf.
module fib_seq_arb
  import fib_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned NW = DefNw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [NW-1:0] n0,
  input  logic [NW-1:0] n1,
  output logic [W-1:0]  res,
  output logic [1:0]    done,
  output logic          busy
`ifdef FIB_OVERFLOW_EN
  ,
  output logic          ovf
`endif
);

  fib_state_e    state_q, state_d;
  logic          prio_q, prio_d;
  logic          owner_q, owner_d;
  logic [NW-1:0] nl_q, nl_d;
  logic [NW-1:0] i_q, i_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;

  logic [1:0]    grant;
  logic          arb_owner;
  logic          start;
  logic [NW-1:0] n_sel;
  logic          short_job;
  logic          calc_last;
  logic [W-1:0]  sum;

  rr_arb2 u_arb (
    .req    (req),
    .prio   (prio_q),
    .enable (state_q == StIdle),
    .grant  (grant),
    .owner  (arb_owner)
  );

  assign start     = |grant;
  assign n_sel     = arb_owner ? n1 : n0;
  assign short_job = (n_sel < NW'(2));
  assign calc_last = (state_q == StCalc) && (i_q == nl_q);

`ifdef FIB_OVERFLOW_EN
  logic [W:0] sum_full;
  logic       carry;
  logic       ovf_int_q, ovf_int_d;
  logic       ovf_q, ovf_d;

  assign sum_full = {1'b0, a_q} + {1'b0, b_q};
  assign sum      = sum_full[W-1:0];
  assign carry    = sum_full[W];

  // Sticky carry tracking; the visible flag is captured together with res.
  always_comb begin
    ovf_int_d = ovf_int_q;
    ovf_d     = ovf_q;
    if (start) begin
      ovf_int_d = 1'b0;
      if (short_job) begin
        ovf_d = 1'b0;
      end
    end else if (state_q == StCalc) begin
      ovf_int_d = ovf_int_q | carry;
      if (calc_last) begin
        ovf_d = ovf_int_q | carry;
      end
    end
  end

  // Overflow state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_int_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_int_q <= ovf_int_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign sum = a_q + b_q;
`endif

  // Next-state logic for the FSM and datapath; res is loaded on the edge entering StDone.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    nl_d    = nl_q;
    i_d     = i_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          owner_d = arb_owner;
          nl_d    = n_sel;
          a_d     = W'(FIB_A0);
          b_d     = W'(FIB_B0);
          i_d     = NW'(2);
          if (short_job) begin
            state_d = StDone;
            res_d   = (n_sel == '0) ? W'(FIB_A0) : W'(FIB_B0);
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        a_d = b_q;
        b_d = sum;
        i_d = i_q + NW'(1);
        if (calc_last) begin
          state_d = StDone;
          res_d   = sum;
        end
      end
      StDone: begin
        prio_d  = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      nl_q    <= '0;
      i_q     <= '0;
      a_q     <= W'(FIB_A0);
      b_q     <= W'(FIB_B0);
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      nl_q    <= nl_d;
      i_q     <= i_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign res  = res_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_fib_seq_arb.sv
// Scoreboard bench for fib_seq_arb: drivers queue expected completions, a monitor checks them.
module tb_fib_seq_arb;

  localparam int unsigned W  = 32;
  localparam int unsigned NW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [NW-1:0] n0  = '0;
  logic [NW-1:0] n1  = '0;
  logic [W-1:0]  res;
  logic [1:0]    done;
  logic          busy;
`ifdef FIB_OVERFLOW_EN
  logic          ovf;
`endif

  fib_seq_arb #(
    .W  (W),
    .NW (NW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .n0   (n0),
    .n1   (n1),
    .res  (res),
    .done (done),
    .busy (busy)
`ifdef FIB_OVERFLOW_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  done;
    logic [W-1:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fib_model(input int n);
    logic [W-1:0] a, b, t;
    a = '0;
    b = 1;
    if (n == 0) return '0;
    for (int j = 2; j <= n; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done", 64'(done), 64'(mon_e.done));
        chk("res", 64'(res), 64'(mon_e.res));
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("busy_at_done", 64'(busy), 64'd1);
`ifdef FIB_OVERFLOW_EN
        chk("ovf", 64'(ovf), 64'(mon_e.ovf));
`endif
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one job from requester idx; req is dropped during the done cycle.
  task automatic run_job(input int idx, input int n, input logic [W-1:0] exp_res,
                         input logic exp_ovf);
    int m;
    int lat;
    m   = cyc;
    lat = (n < 2) ? 1 : n;
    if (idx == 0) n0 = NW'(n);
    else          n1 = NW'(n);
    req[idx] = 1'b1;
    sb.push_back('{m + lat, (idx == 0) ? 2'b01 : 2'b10, exp_res, exp_ovf});
    wait_until(m + lat);
    req[idx] = 1'b0;
    wait_until(m + lat + 2);
  endtask

  initial begin
    int m;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res", 64'(res), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
`ifdef FIB_OVERFLOW_EN
    chk("reset_ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    wait_until(cyc + 1);

    run_job(0, 5, 32'd5, 1'b0);

    // Asynchronous reset mid-CALC aborts silently.
    m  = cyc;
    n0 = NW'(20);
    req[0] = 1'b1;
    wait_until(m + 5);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_res", 64'(res), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_until(cyc + 1);
    run_job(0, 5, 32'd5, 1'b0);

    // n0=10 with busy window checks.
    m  = cyc;
    n0 = NW'(10);
    req[0] = 1'b1;
    sb.push_back('{m + 10, 2'b01, 32'd55, 1'b0});
    chk("busy_before", 64'(busy), 64'd0);
    wait_until(m + 1);
    chk("busy_first", 64'(busy), 64'd1);
    wait_until(m + 10);
    chk("busy_last", 64'(busy), 64'd1);
    req[0] = 1'b0;
    wait_until(m + 11);
    chk("busy_after", 64'(busy), 64'd0);
    wait_until(m + 12);

    // Short jobs on requester 1.
    run_job(1, 0, 32'd0, 1'b0);
    run_job(1, 1, 32'd1, 1'b0);

    // Both requesters held: 0 wins first, then 1, then 0 again.
    m  = cyc;
    n0 = NW'(3);
    n1 = NW'(4);
    req = 2'b11;
    sb.push_back('{m + 3, 2'b01, 32'd2, 1'b0});
    sb.push_back('{m + 8, 2'b10, 32'd3, 1'b0});
    sb.push_back('{m + 12, 2'b01, 32'd2, 1'b0});
    wait_until(m + 8);
    req[1] = 1'b0;
    wait_until(m + 12);
    req[0] = 1'b0;
    wait_until(m + 14);

    // Largest value without wrap, and the first wrapping one.
    run_job(0, 47, 32'd2971215073, 1'b0);
    run_job(0, 48, 32'd512559680, 1'b1);

    // Index change and req drop during CALC are ignored.
    m  = cyc;
    n0 = NW'(10);
    req[0] = 1'b1;
    sb.push_back('{m + 10, 2'b01, 32'd55, 1'b0});
    wait_until(m + 3);
    n0 = NW'(3);
    req[0] = 1'b0;
    wait_until(m + 12);

    // Maximum index.
    run_job(1, 255, fib_model(255), 1'b1);

    wait_until(cyc + 3);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
